comp_seq_ctrl: RTL and testbench
================================

Name: comp_seq_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands with a single internal 2-bit magnitude-compare slice (lt/eq/gt), two bits per cycle, MSB pair first.
- Stops early on the first unequal pair.
- Start/busy/done handshake plus an enable that pauses the sweep.
- Sits between a requesting control unit and the shared compare slice; trades latency for area against a flat WIDTH-bit comparator.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2; odd values are a configuration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a compare; sampled only in IDLE
- en  input  1  enable; gates acceptance of start and advancement of the sweep
- a  input  WIDTH  operand A; captured when start is accepted
- b  input  WIDTH  operand B; captured when start is accepted
- busy  output  1  high while a compare is in progress
- done  output  1  one-cycle pulse when the result is valid
- lt  output  1  A < B (registered, held)
- eq  output  1  A == B (registered, held)
- gt  output  1  A > B (registered, held)
- pairs  output  $clog2(WIDTH/2)+1  number of 2-bit pairs examined for the last result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, lt, eq, gt = 0; pairs = 0; internal shift registers and counter = 0. Reset mid-compare aborts with no done pulse.
- States: IDLE, COMPARE.
- IDLE:
  - On an edge with start=1 and en=1: load a/b into shift regs, counter=0, clear lt/eq/gt/pairs to 0, busy=1, go to COMPARE.
  - start with en=0 is ignored.
- COMPARE, each edge with en=1:
  - Slice compares the top 2 bits of the A and B shift regs; counter increments.
  - If the pair is unequal: set lt or gt accordingly, pairs = counter+1, done=1, busy=0, go to IDLE.
  - Else if this was the last pair (counter = WIDTH/2-1): eq=1, pairs=WIDTH/2, done=1, busy=0, go to IDLE.
  - Else: shift both regs left by 2 and stay in COMPARE.
- COMPARE with en=0: hold all state. No shift, no count, busy stays 1.
- start asserted while busy is ignored; the operands in flight are unaffected. a/b changes after capture have no effect.
- done is high exactly one cycle, in the cycle after the deciding edge.
- lt/eq/gt/pairs hold their values until the next accepted start; exactly one of lt/eq/gt is 1 after any done.
- Latency, with no pauses: start accepted at edge E0; the first differing pair index k (0 = MSB pair) gives done after edge E(k+1). Equal operands give done after E(WIDTH/2). Each en=0 cycle in COMPARE adds one cycle.
- Back-to-back operation: since the FSM is in IDLE during the done cycle, start=1 in that cycle is accepted at the next edge. Results are then cleared and busy rises.
- Unsigned comparison only; no sign handling.

Test Plan:
- WIDTH=8, a=8'hA5, b=8'hA5, start=1, en=1 for one cycle -> busy for 4 cycles, then done pulse; eq=1, lt=gt=0, pairs=4.
- a=8'hC0, b=8'h40 -> MSB pair 11 vs 01; done 1 cycle after start accepted; gt=1, pairs=1.
- a=8'h12, b=8'h13 -> last pair 10 vs 11; lt=1, pairs=4, done 4 cycles after start.
- a=8'h12, b=8'h13, en dropped for 3 cycles after the first compare edge -> done delayed to 7 cycles after start; lt=1, pairs=4. Also start with en=0 in IDLE -> no busy.
- Start a=8'hFF, b=8'h00; during busy, pulse start with a=b=0 -> ignored, gt=1. Separately, assert rst_n=0 mid-compare -> all outputs 0 immediately (asynchronously), no done, IDLE afterwards.
- Assert start in the done cycle with new operands a=8'h01, b=8'h02 -> accepted next edge; lt/eq/gt cleared; later lt=1, pairs=4.

Source files
------------

// File: rtl/comp_seq_ctrl_if.sv
// rtl/comp_seq_ctrl_if.sv - start/en/operand/result bundle between a control unit and comp_seq_ctrl
interface comp_seq_ctrl_if #(
  parameter int WIDTH = 8
);
  localparam int PW = $clog2(WIDTH / 2) + 1;

  logic             start;
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;
  logic [PW-1:0]    pairs;

  modport master (
    output start, en, a, b,
    input  busy, done, lt, eq, gt, pairs
  );

  modport slave (
    input  start, en, a, b,
    output busy, done, lt, eq, gt, pairs
  );
endinterface

// File: rtl/comp_seq_ctrl.sv
// rtl/comp_seq_ctrl.sv - unsigned compare, two bits per cycle MSB first, early exit on first unequal pair
module comp_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  comp_seq_ctrl_if.slave bus
);
  localparam int NP = WIDTH / 2;
  localparam int PW = $clog2(NP) + 1;
  localparam logic [PW-1:0] LAST     = PW'(NP - 1);
  localparam logic [PW-1:0] NP_PAIRS = PW'(NP);

  generate
    if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("comp_seq_ctrl: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sa, sa_n, sb, sb_n;
  logic [PW-1:0]    cnt, cnt_n;
  logic [PW-1:0]    pairs_q, pairs_n;
  logic             lt_q, lt_n, eq_q, eq_n, gt_q, gt_n;
  logic             done_q, done_n;
  logic [1:0]       pa, pb;

  // the shared 2-bit slice always looks at the top pair of the shift registers
  assign pa = sa[WIDTH-1 -: 2];
  assign pb = sb[WIDTH-1 -: 2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      pairs_q <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      sa      <= sa_n;
      sb      <= sb_n;
      cnt     <= cnt_n;
      pairs_q <= pairs_n;
      lt_q    <= lt_n;
      eq_q    <= eq_n;
      gt_q    <= gt_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    sa_n    = sa;
    sb_n    = sb;
    cnt_n   = cnt;
    pairs_n = pairs_q;
    lt_n    = lt_q;
    eq_n    = eq_q;
    gt_n    = gt_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && bus.en) begin
          sa_n    = bus.a;
          sb_n    = bus.b;
          cnt_n   = '0;
          pairs_n = '0;
          lt_n    = 1'b0;
          eq_n    = 1'b0;
          gt_n    = 1'b0;
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.en) begin
          cnt_n = cnt + PW'(1);
          if (pa != pb) begin
            lt_n    = (pa < pb);
            gt_n    = (pa > pb);
            pairs_n = cnt + PW'(1);
            done_n  = 1'b1;
            state_n = IDLE;
          end else if (cnt == LAST) begin
            eq_n    = 1'b1;
            pairs_n = NP_PAIRS;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            sa_n = sa << 2;
            sb_n = sb << 2;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy  = (state == COMPARE);
  assign bus.done  = done_q;
  assign bus.lt    = lt_q;
  assign bus.eq    = eq_q;
  assign bus.gt    = gt_q;
  assign bus.pairs = pairs_q;
endmodule

// File: tb/tb_comp_seq_ctrl.sv
// tb/tb_comp_seq_ctrl.sv - directed and randomized checks of comp_seq_ctrl against a reference model
module tb_comp_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int NP    = WIDTH / 2;
  localparam int PW    = $clog2(NP) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  comp_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

  comp_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         checks = 0;
  int         errors = 0;
  logic [2:0] last_rel = 3'b000;
  int         last_pairs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {lt,eq,gt} from plain unsigned arithmetic; pairs = index of first differing pair + 1, or NP
  function automatic void model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                output logic [2:0] rel, output int np);
    rel = (av < bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
    np  = NP;
    for (int i = 0; i < NP; i++) begin
      if (((av >> (WIDTH - 2 - 2 * i)) & 3) != ((bv >> (WIDTH - 2 - 2 * i)) & 3)) begin
        np = i + 1;
        break;
      end
    end
  endfunction

  // Entered and left at a falling edge; leaves in the done cycle so a following call is back-to-back.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic [63:0] pmask, input int inj_edge);
    logic [2:0] exp_rel;
    int         exp_pairs;
    int         done_n;
    int         active;
    model(av, bv, exp_rel, exp_pairs);
    done_n = 0;
    active = 0;
    for (int n = 1; n < 64 && done_n == 0; n++) begin
      if (!pmask[n]) active++;
      if (active == exp_pairs) done_n = n;
    end
    bus.start = 1'b1;
    bus.en    = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
    @(negedge clk);
    chk("accept_busy_done", {30'd0, bus.busy, bus.done}, 32'h2);
    chk("accept_cleared", {bus.lt, bus.eq, bus.gt, bus.pairs}, '0);
    for (int n = 1; n <= done_n; n++) begin
      bus.en = !pmask[n];
      if (n == inj_edge) begin
        bus.start = 1'b1;
        bus.a     = '0;
        bus.b     = '0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("busy_done_e%0d", n), {30'd0, bus.busy, bus.done},
          (n == done_n) ? 32'h1 : 32'h2);
    end
    bus.start = 1'b0;
    bus.en    = 1'b1;
    chk("result_rel", {29'd0, bus.lt, bus.eq, bus.gt}, {29'd0, exp_rel});
    chk("result_pairs", 32'(bus.pairs), exp_pairs);
    last_rel   = exp_rel;
    last_pairs = exp_pairs;
  endtask

  task automatic idle_cycle();
    bus.start = 1'b0;
    bus.en    = 1'($urandom);
    @(negedge clk);
    chk("idle_busy_done", {30'd0, bus.busy, bus.done}, 32'h0);
    chk("idle_held", {bus.lt, bus.eq, bus.gt, bus.pairs}, {last_rel, PW'(last_pairs)});
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [63:0]      pm;
    int               inj;

    bus.start = 1'b0;
    bus.en    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs", {bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.pairs}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", {bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.pairs}, '0);

    run_op(8'hA5, 8'hA5, 64'h0, -1);
    idle_cycle();
    run_op(8'hC0, 8'h40, 64'h0, -1);
    idle_cycle();
    run_op(8'h12, 8'h13, 64'h0, -1);
    idle_cycle();
    run_op(8'h12, 8'h13, 64'h1C, -1);
    idle_cycle();

    // start without en in IDLE is ignored
    bus.start = 1'b1;
    bus.en    = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'hFF;
    @(negedge clk);
    chk("start_no_en_busy", {31'd0, bus.busy}, 32'h0);
    @(negedge clk);
    chk("start_no_en_held", {bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.pairs},
        {2'b00, last_rel, PW'(last_pairs)});
    bus.start = 1'b0;

    run_op(8'hFF, 8'h00, 64'h0, 1);
    idle_cycle();
    run_op(8'h3C, 8'h3C, 64'h0, 2);
    run_op(8'h01, 8'h02, 64'h0, -1);
    idle_cycle();

    // asynchronous reset in the middle of a compare
    bus.start = 1'b1;
    bus.en    = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h55;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    chk("midreset_busy_before", {31'd0, bus.busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_async_clear", {bus.busy, bus.done, bus.lt, bus.eq, bus.gt, bus.pairs}, '0);
    @(negedge clk);
    rst_n      = 1'b1;
    last_rel   = 3'b000;
    last_pairs = 0;
    for (int i = 0; i < 5; i++) idle_cycle();

    for (int t = 0; t < 30; t++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(2, 0))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'($urandom_range(3, 1) << (2 * $urandom_range(NP - 1, 0)));
        default: rb = WIDTH'($urandom);
      endcase
      pm  = {$urandom, $urandom} & {$urandom, $urandom} & 64'h0000_0000_01FF_FFFE;
      inj = ($urandom_range(1, 0) == 1) ? int'($urandom_range(NP, 1)) : -1;
      run_op(ra, rb, pm, inj);
      if ($urandom_range(1, 0) == 1) idle_cycle();
    end
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
